// File: rtl/jt49_bus_if.sv
// AY-3-8910 style CPU-side bus bundle: bus-control lines, chip selects,
// the multiplexed DA bus and its read-back drive enable.
interface jt49_bus_if;
  logic       bdir;
  logic       bc2;
  logic       bc1;
  logic       a8;
  logic       a9_n;
  logic [7:0] da_in;
  logic [7:0] da_out;
  logic       da_oe;

  modport master (
    output bdir, bc2, bc1, a8, a9_n, da_in,
    input  da_out, da_oe
  );

  modport slave (
    input  bdir, bc2, bc1, a8, a9_n, da_in,
    output da_out, da_oe
  );
endinterface

// File: rtl/jt49_bus.sv
// AY-3-8910 bus decoder for the jt49 core: synchronises BDIR/BC2/BC1, filters
// glitches, latches the register index and turns bus cycles into core strobes.
module jt49_bus #(
  parameter int SYNC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bdir,
  input  logic       bc2,
  input  logic       bc1,
  input  logic       a8,
  input  logic       a9_n,
  input  logic [7:0] da_in,
  output logic [7:0] da_out,
  output logic       da_oe,
  output logic [3:0] addr,
  output logic       cs_n,
  output logic       wr_n,
  output logic [7:0] din,
  input  logic [7:0] core_dout
);

  typedef enum logic [1:0] {IDLE, LATCH, WRITE, READ} state_t;

  logic [12:0] bus_raw;
  logic [12:0] bus;

  assign bus_raw = {bdir, bc2, bc1, a8, a9_n, da_in};

  if (SYNC != 0) begin : g_sync2
    logic [12:0] stg1_q;
    logic [12:0] stg2_q;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        stg1_q <= '0;
        stg2_q <= '0;
      end else begin
        stg1_q <= bus_raw;
        stg2_q <= stg1_q;
      end
    end
    assign bus = stg2_q;
  end else begin : g_sync1
    logic [12:0] stg1_q;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        stg1_q <= '0;
      end else begin
        stg1_q <= bus_raw;
      end
    end
    assign bus = stg1_q;
  end

  logic [2:0] code;
  logic       bus_a8;
  logic       bus_a9_n;
  logic [7:0] bus_da;
  logic       stable;
  logic       hit;

  assign code     = bus[12:10];
  assign bus_a8   = bus[9];
  assign bus_a9_n = bus[8];
  assign bus_da   = bus[7:0];

  state_t     state_q, state_d;
  logic [2:0] code_prev_q;
  logic       sel_q, sel_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] din_q, din_d;
  logic [7:0] da_out_q, da_out_d;
  logic       da_oe_q, da_oe_d;
  logic       cs_n_q, cs_n_d;
  logic       wr_n_q, wr_n_d;
  logic       strobe;
  logic       reading;

  assign stable = (code == code_prev_q);
  assign hit    = (bus_da[7:4] == 4'h0) && bus_a8 && !bus_a9_n;

  always_comb begin
    state_d = state_q;
    if (stable) begin
      case (code)
        3'b001, 3'b100, 3'b111: state_d = LATCH;
        3'b110:                 state_d = WRITE;
        3'b011:                 state_d = READ;
        default:                state_d = IDLE;
      endcase
    end

    sel_d  = sel_q;
    addr_d = addr_q;
    if (stable && state_d == LATCH) begin
      sel_d = hit;
      if (hit) addr_d = bus_da[3:0];
    end

    // Capture only while the sampled code still reads 110, so the data that
    // arrives alongside the exit code never overwrites the write value.
    hold_d = hold_q;
    if (code == 3'b110 && (state_q == WRITE || stable)) hold_d = bus_da;

    // Any stable exit from WRITE (including straight into READ/LATCH) strobes;
    // the strobe cycle suppresses the read enable so wr_n and da_oe never overlap.
    strobe  = (state_q == WRITE) && (state_d != WRITE) && sel_q;
    reading = (state_d == READ) && sel_q && !strobe;

    din_d    = strobe ? hold_q : din_q;
    wr_n_d   = !strobe;
    cs_n_d   = !(strobe || reading);
    da_oe_d  = reading;
    da_out_d = reading ? core_dout : da_out_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      code_prev_q <= '0;
      sel_q       <= 1'b0;
      addr_q      <= '0;
      hold_q      <= '0;
      din_q       <= '0;
      da_out_q    <= '0;
      da_oe_q     <= 1'b0;
      cs_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      code_prev_q <= code;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      hold_q      <= hold_d;
      din_q       <= din_d;
      da_out_q    <= da_out_d;
      da_oe_q     <= da_oe_d;
      cs_n_q      <= cs_n_d;
      wr_n_q      <= wr_n_d;
    end
  end

  assign addr   = addr_q;
  assign din    = din_q;
  assign da_out = da_out_q;
  assign da_oe  = da_oe_q;
  assign cs_n   = cs_n_q;
  assign wr_n   = wr_n_q;

endmodule
